fpu_addsub: RTL and testbench
=============================

Name: fpu_addsub

Overview:
- IEEE-754 single-precision add/subtract datapath, multi-cycle, FSM-sequenced. Sits behind the FPU test interface as the device under test.
- Accepts operands on a start/busy/done handshake and returns a registered result plus exception flags.
- Denormal inputs and outputs are flushed to zero. Rounding is round-to-nearest-even or truncation, selected by the optional feature below.

Parameters:
- ALIGN_CAP, 26: exponent difference above which the smaller operand collapses to a sticky bit in one cycle.
- FAST_SHIFT, 0: 1 performs alignment and normalisation shifts as a single-cycle barrel shift; 0 shifts one bit per cycle.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- arst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only while busy=0.
- op_sub  in  1  1 computes a-b; 0 computes a+b.
- a  in  32  operand A, FP32.
- b  in  32  operand B, FP32.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result and flags are valid.
- result  out  32  FP32 result, held until the next done.
- flags  out  4  {invalid, overflow, underflow, inexact}, held with result.

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, result and flags all 0. Reset mid-operation aborts it and produces no done.
- Handshake:
  - start with busy=0 latches a, b and op_sub; busy=1 from the next cycle through the DONE cycle inclusive.
  - start while busy=1 is ignored.
  - A start in the cycle after done is accepted.
- States:
  - IDLE -> UNPACK on start.
  - UNPACK -> DONE for special cases, else -> ALIGN.
  - ALIGN -> ADD.
  - ADD -> NORM.
  - NORM -> ROUND.
  - ROUND -> DONE.
  - DONE -> IDLE.
- UNPACK:
  - Effective sign of b is b[31]^op_sub. Exponent 0 means zero (FTZ).
  - Any NaN gives 0x7FC00000, invalid=1.
  - inf with inf under effective subtraction gives 0x7FC00000, invalid=1.
  - inf with any finite operand gives inf carrying the inf operand's effective sign.
  - zero with zero gives 0 with sign = sa&sb_eff.
  - zero with x gives x (sign adjusted for op_sub), no flags.
  - Otherwise swap so the larger magnitude (exponent, then mantissa) is X.
- ALIGN:
  - Significands are 24 bits with hidden 1, plus G/R/S bits, plus a carry bit.
  - d = eX-eY. If d > ALIGN_CAP: Y becomes S=1 only, in one cycle.
  - Otherwise shift Y right d places, ORing every bit shifted out into S.
  - FAST_SHIFT=0 takes max(d,1) cycles; FAST_SHIFT=1 takes 1 cycle.
- ADD: same signs add; different signs compute X-Y (never negative). Result sign is X's sign.
- NORM:
  - Carry set: shift right 1 (into sticky), exponent+1.
  - Zero result: +0, skip to ROUND with no flags.
  - Else shift left until the hidden bit is 1, exponent-1 per shift.
  - Exponent reaching 0: result ±0, underflow=1, inexact=1.
  - FAST_SHIFT=0 takes up to 24 cycles.
- ROUND:
  - inexact = G|R|S.
  - Mantissa overflow after increment: exponent+1.
  - Exponent >=255: overflow=1, inexact=1; value per the optional feature.
- Latency: FAST_SHIFT=1 gives a fixed 6 cycles from start to done. FAST_SHIFT=0 is bounded by 6+ALIGN_CAP+24.
- Simultaneous start and done-cycle: start is ignored, since busy=1.

Optional Feature:
- Macro FPU_RNE_EN.
- Defined:
  - Round-to-nearest-even: increment when G&(R|S|LSB).
  - Overflow returns ±inf (0x7F800000 / 0xFF800000).
- Undefined:
  - Truncation (round toward zero): never increments.
  - Overflow returns ±max finite (0x7F7FFFFF / 0xFF7FFFFF).
- Both modes: overflow and inexact flags set identically.

Test Plan:
- a=0x3F800000, b=0x40000000, op_sub=0 -> result 0x40400000, flags 0000, done exactly once, busy high until done.
- a=0x3F800000, b=0x3F800000, op_sub=1 -> result 0x00000000, flags 0000.
- a=0x3F800001, b=0x33800000 (exact tie), add -> FPU_RNE_EN gives 0x3F800002; without the macro gives 0x3F800001. Inexact=1 in both.
- a=b=0x7F7FFFFF, add -> FPU_RNE_EN gives 0x7F800000; without gives 0x7F7FFFFF. Overflow=1, inexact=1 in both.
- a=0x7F800000, b=0x7F800000, op_sub=1 -> result 0x7FC00000, invalid=1. Any NaN input gives the same result.
- Start 0x3F800000+0x33000000, pulse start again while busy with different operands -> first result only (0x3F800000, inexact=1).
  - Then start a new op and assert arst mid-ALIGN -> no done; busy/result/flags 0.
  - Next start works normally.

Source files
------------

// File: rtl/fpu_addsub.sv
// FP32 add/subtract, FSM-sequenced, flush-to-zero for denormals.
// Rounding: define FPU_RNE_EN for round-to-nearest-even, otherwise truncation.
module fpu_addsub #(
    parameter int unsigned ALIGN_CAP  = 26,
    parameter int unsigned FAST_SHIFT = 0
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        start,
    input  logic        op_sub,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [3:0]  flags
);

    typedef enum logic [2:0] {
        StIdle,
        StUnpack,
        StAlign,
        StAdd,
        StNorm,
        StRound,
        StDone
    } state_e;

    // Significand layout: [27] carry, [26] hidden, [25:3] fraction, [2] G, [1] R, [0] S.
    state_e      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic        sub_q, sub_d;
    logic        sx_q, sx_d, sy_q, sy_d;
    logic [9:0]  ex_q, ex_d;
    logic [27:0] mx_q, mx_d, my_q, my_d;
    logic [7:0]  d_q, d_d;
    logic        zero_q, zero_d, uf_q, uf_d;
    logic [31:0] result_q;
    logic [3:0]  flags_q;

    logic        load;
    logic [31:0] out_res;
    logic [3:0]  out_flags;

    function automatic logic [27:0] shr_sticky(input logic [27:0] v, input logic [7:0] n);
        logic [27:0] mask;
        logic [27:0] r;
        mask = (28'd1 << n) - 28'd1;
        r = v >> n;
        r[0] = r[0] | (|(v & mask));
        return r;
    endfunction

    function automatic logic [4:0] lzc(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

    // Operand decode
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        sa, sb;
    logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic        a_ge_b;

    assign ea     = a_q[30:23];
    assign eb     = b_q[30:23];
    assign fa     = a_q[22:0];
    assign fb     = b_q[22:0];
    assign sa     = a_q[31];
    assign sb     = b_q[31] ^ sub_q;
    assign nan_a  = (ea == 8'hFF) && (fa != 23'd0);
    assign nan_b  = (eb == 8'hFF) && (fb != 23'd0);
    assign inf_a  = (ea == 8'hFF) && (fa == 23'd0);
    assign inf_b  = (eb == 8'hFF) && (fb == 23'd0);
    assign zero_a = (ea == 8'd0);
    assign zero_b = (eb == 8'd0);
    assign a_ge_b = (a_q[30:0] >= b_q[30:0]);

    logic        special;
    logic [31:0] spec_res;
    logic [3:0]  spec_flags;

    always_comb begin
        special    = 1'b1;
        spec_res   = 32'd0;
        spec_flags = 4'b0000;
        if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
            spec_res   = 32'h7FC0_0000;
            spec_flags = 4'b1000;
        end else if (inf_a) begin
            spec_res = {sa, 8'hFF, 23'd0};
        end else if (inf_b) begin
            spec_res = {sb, 8'hFF, 23'd0};
        end else if (zero_a && zero_b) begin
            spec_res = {sa & sb, 31'd0};
        end else if (zero_a) begin
            spec_res = {sb, b_q[30:0]};
        end else if (zero_b) begin
            spec_res = {sa, a_q[30:0]};
        end else begin
            special = 1'b0;
        end
    end

    // Rounding datapath
    logic        rinc;
    logic [24:0] rsum;
    logic [9:0]  rexp;
    logic        inexact;
    logic [4:0]  lz;

    assign lz      = lzc(mx_q[26:0]);
    assign inexact = |mx_q[2:0];
`ifdef FPU_RNE_EN
    assign rinc = mx_q[2] & (mx_q[1] | mx_q[0] | mx_q[3]);
`else
    assign rinc = 1'b0;
`endif
    assign rsum = {1'b0, mx_q[26:3]} + {24'd0, rinc};
    assign rexp = ex_q + {9'd0, rsum[24]};

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sub_d     = sub_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        ex_d      = ex_q;
        mx_d      = mx_q;
        my_d      = my_q;
        d_d       = d_q;
        zero_d    = zero_q;
        uf_d      = uf_q;
        load      = 1'b0;
        out_res   = result_q;
        out_flags = flags_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = op_sub;
                    state_d = StUnpack;
                end
            end
            StUnpack: begin
                if (special) begin
                    load      = 1'b1;
                    out_res   = spec_res;
                    out_flags = spec_flags;
                    state_d   = StDone;
                end else begin
                    zero_d = 1'b0;
                    uf_d   = 1'b0;
                    if (a_ge_b) begin
                        sx_d = sa;
                        sy_d = sb;
                        ex_d = {2'b00, ea};
                        mx_d = {2'b01, fa, 3'b000};
                        my_d = {2'b01, fb, 3'b000};
                        d_d  = ea - eb;
                    end else begin
                        sx_d = sb;
                        sy_d = sa;
                        ex_d = {2'b00, eb};
                        mx_d = {2'b01, fb, 3'b000};
                        my_d = {2'b01, fa, 3'b000};
                        d_d  = eb - ea;
                    end
                    state_d = StAlign;
                end
            end
            StAlign: begin
                if (32'(d_q) > ALIGN_CAP) begin
                    my_d    = 28'd1;
                    state_d = StAdd;
                end else if (FAST_SHIFT != 0 || d_q <= 8'd1) begin
                    my_d    = shr_sticky(my_q, d_q);
                    state_d = StAdd;
                end else begin
                    my_d = shr_sticky(my_q, 8'd1);
                    d_d  = d_q - 8'd1;
                end
            end
            StAdd: begin
                // X is the larger magnitude, so the difference never goes negative.
                mx_d    = (sx_q == sy_q) ? mx_q + my_q : mx_q - my_q;
                state_d = StNorm;
            end
            StNorm: begin
                if (mx_q[27]) begin
                    mx_d    = shr_sticky(mx_q, 8'd1);
                    ex_d    = ex_q + 10'd1;
                    state_d = StRound;
                end else if (mx_q == 28'd0) begin
                    zero_d  = 1'b1;
                    state_d = StRound;
                end else if (mx_q[26]) begin
                    state_d = StRound;
                end else if (FAST_SHIFT != 0) begin
                    if (ex_q <= {5'd0, lz}) begin
                        uf_d = 1'b1;
                    end else begin
                        mx_d = mx_q << lz;
                        ex_d = ex_q - {5'd0, lz};
                    end
                    state_d = StRound;
                end else if (ex_q == 10'd1) begin
                    uf_d    = 1'b1;
                    state_d = StRound;
                end else begin
                    mx_d = mx_q << 1;
                    ex_d = ex_q - 10'd1;
                end
            end
            StRound: begin
                load    = 1'b1;
                state_d = StDone;
                if (zero_q) begin
                    out_res   = 32'd0;
                    out_flags = 4'b0000;
                end else if (uf_q) begin
                    out_res   = {sx_q, 31'd0};
                    out_flags = 4'b0011;
                end else if (rexp >= 10'd255) begin
`ifdef FPU_RNE_EN
                    out_res = {sx_q, 8'hFF, 23'd0};
`else
                    out_res = {sx_q, 8'hFE, 23'h7F_FFFF};
`endif
                    out_flags = 4'b0101;
                end else begin
                    out_res   = {sx_q, rexp[7:0], rsum[24] ? 23'd0 : rsum[22:0]};
                    out_flags = {3'b000, inexact};
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= StIdle;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            sub_q    <= 1'b0;
            sx_q     <= 1'b0;
            sy_q     <= 1'b0;
            ex_q     <= 10'd0;
            mx_q     <= 28'd0;
            my_q     <= 28'd0;
            d_q      <= 8'd0;
            zero_q   <= 1'b0;
            uf_q     <= 1'b0;
            result_q <= 32'd0;
            flags_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            ex_q    <= ex_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
            d_q     <= d_d;
            zero_q  <= zero_d;
            uf_q    <= uf_d;
            if (load) begin
                result_q <= out_res;
                flags_q  <= out_flags;
            end
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_fpu_addsub.sv
// Scoreboard bench for fpu_addsub: directed vectors, expectations queued at issue time.
module tb_fpu_addsub;

    logic        clk = 1'b0;
    logic        arst;
    logic        start;
    logic        op_sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [3:0]  flags;

    int total = 0;
    int bad   = 0;

    logic [31:0] q_res[$];
    logic [3:0]  q_flg[$];
    string       q_tag[$];

    fpu_addsub dut (
        .clk    (clk),
        .arst   (arst),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flags  (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (q_res.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1, want done=0");
                end else begin
                    string       t;
                    logic [31:0] r;
                    logic [3:0]  f;
                    t = q_tag.pop_front();
                    r = q_res.pop_front();
                    f = q_flg.pop_front();
                    check({t, "_result"}, result, r);
                    check({t, "_flags"}, {28'd0, flags}, {28'd0, f});
                end
            end
        end
    endtask

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                         input bit push, input logic [31:0] er, input logic [3:0] ef,
                         input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        a      = ia;
        b      = ib;
        op_sub = isub;
        start  = 1'b1;
        if (push) begin
            q_res.push_back(er);
            q_flg.push_back(ef);
            q_tag.push_back(tag);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called right after issue(); requires busy every cycle until done, then done drops.
    task automatic wait_done(input string tag);
        int   n;
        logic busy_ok;
        n       = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && n < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_held"}, {31'd0, busy_ok & busy}, 32'd1);
        @(negedge clk);
        check({tag, "_done_once"}, {31'd0, done}, 32'd0);
    endtask

    task automatic run(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                       input logic [31:0] er, input logic [3:0] ef, input string tag);
        issue(ia, ib, isub, 1'b1, er, ef, tag);
        wait_done(tag);
    endtask

    logic [31:0] tie_exp;
    logic [31:0] ovf_exp;

    initial begin
`ifdef FPU_RNE_EN
        tie_exp = 32'h3F80_0002;
        ovf_exp = 32'h7F80_0000;
`else
        tie_exp = 32'h3F80_0001;
        ovf_exp = 32'h7F7F_FFFF;
`endif
        arst   = 1'b0;
        start  = 1'b0;
        op_sub = 1'b0;
        a      = 32'd0;
        b      = 32'd0;
        fork
            monitor();
        join_none
        #1 arst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_flags", {28'd0, flags}, 32'd0);
        arst = 1'b0;

        run(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 4'b0000, "one_plus_two");
        run(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 4'b0000, "one_minus_one");
        run(32'h3F80_0001, 32'h3380_0000, 1'b0, tie_exp, 4'b0001, "tie");
        run(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, ovf_exp, 4'b0101, "overflow");
        run(32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 4'b1000, "inf_minus_inf");
        run(32'h7F80_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 4'b1000, "nan_in");
        run(32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 4'b0000, "three_minus_one");
        run(32'h3F80_0000, 32'h3F40_0000, 1'b1, 32'h3E80_0000, 4'b0000, "norm_left");
        run(32'h0000_0000, 32'h3F80_0000, 1'b1, 32'hBF80_0000, 4'b0000, "zero_minus_x");
        run(32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0000, 4'b0011, "underflow");

        // Second start while busy must be dropped.
        issue(32'h3F80_0000, 32'h3300_0000, 1'b0, 1'b1, 32'h3F80_0000, 4'b0001, "busy_start");
        @(negedge clk);
        a     = 32'h4000_0000;
        b     = 32'h4000_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start");
        repeat (80) @(negedge clk);
        check("busy_start_idle", {31'd0, busy}, 32'd0);

        // Abort during ALIGN: no done, everything cleared.
        issue(32'h3F80_0000, 32'h3A00_0000, 1'b0, 1'b0, 32'd0, 4'd0, "abort");
        @(negedge clk);
        arst = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_flags", {28'd0, flags}, 32'd0);
        arst = 1'b0;
        repeat (60) @(negedge clk);

        run(32'h3F80_0000, 32'h3A00_0000, 1'b0, 32'h3F80_1000, 4'b0000, "after_abort");

        repeat (5) @(negedge clk);
        check("scoreboard_empty", q_res.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
